// File: rtl/cpu_prog_loader.sv
// Program loader for the 8-bit CPU tile: header N, then N payload words into program memory.
// Define LOADER_CSUM_EN to require a trailing XOR checksum word before the CPU is released.
module cpu_prog_loader #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ena,
   input  logic              ld_start,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              ld_valid,
   output logic              ld_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              cpu_run,
   output logic              busy,
   output logic              error
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   // Count must reach DEPTH itself, so it needs one bit above the address.
   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam int unsigned CMP_W = ((DATA_W > CNT_W) ? DATA_W : CNT_W) + 1;

   typedef enum logic [2:0] {
      StIdle,
      StHdr,
      StLoad,
`ifdef LOADER_CSUM_EN
      StCsum,
`endif
      StRun,
      StError
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  n_len;
`ifdef LOADER_CSUM_EN
   logic [DATA_W-1:0] csum;
`endif

   logic              xfer;
   logic              last_word;
   logic [CMP_W-1:0]  hdr_ext;
   logic              hdr_bad;

   always_comb begin
      busy = 1'b0;
      case (state)
         StHdr, StLoad: busy = 1'b1;
`ifdef LOADER_CSUM_EN
         StCsum:        busy = 1'b1;
`endif
         default:       busy = 1'b0;
      endcase
   end

   assign ld_ready  = ena & busy;
   assign xfer      = ld_valid & ld_ready;
   assign last_word = (count + CNT_W'(1)) == n_len;
   assign hdr_ext   = CMP_W'(ld_data);
   assign hdr_bad   = (hdr_ext == '0) || (hdr_ext > CMP_W'(DEPTH));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= StIdle;
         count     <= '0;
         n_len     <= '0;
`ifdef LOADER_CSUM_EN
         csum      <= '0;
`endif
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cpu_run   <= 1'b0;
         error     <= 1'b0;
      end else if (!ena) begin
         // Frozen, but a write strobe never outlives its single cycle.
         mem_we <= 1'b0;
      end else begin
         mem_we <= 1'b0;
         if (ld_start) begin
            // Restart wins over any word offered in the same cycle.
            state   <= StHdr;
            count   <= '0;
            cpu_run <= 1'b0;
            error   <= 1'b0;
`ifdef LOADER_CSUM_EN
            csum    <= '0;
`endif
         end else begin
            case (state)
               StHdr: begin
                  if (xfer) begin
                     if (hdr_bad) begin
                        state <= StError;
                        error <= 1'b1;
                     end else begin
                        n_len <= CNT_W'(ld_data);
                        count <= '0;
`ifdef LOADER_CSUM_EN
                        csum  <= '0;
`endif
                        state <= StLoad;
                     end
                  end
               end
               StLoad: begin
                  if (xfer) begin
                     mem_we    <= 1'b1;
                     mem_addr  <= count[ADDR_W-1:0];
                     mem_wdata <= ld_data;
                     count     <= count + CNT_W'(1);
`ifdef LOADER_CSUM_EN
                     csum      <= csum ^ ld_data;
                     if (last_word) state <= StCsum;
`else
                     if (last_word) begin
                        state   <= StRun;
                        cpu_run <= 1'b1;
                     end
`endif
                  end
               end
`ifdef LOADER_CSUM_EN
               StCsum: begin
                  if (xfer) begin
                     if (ld_data == csum) begin
                        state   <= StRun;
                        cpu_run <= 1'b1;
                     end else begin
                        state <= StError;
                        error <= 1'b1;
                     end
                  end
               end
`endif
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cpu_prog_loader.sv
// Self-checking bench for cpu_prog_loader: directed scenarios plus randomized images
// checked against an image-level reference model (honours LOADER_CSUM_EN).
module tb_cpu_prog_loader;
   localparam int DATA_W = 8;
   localparam int ADDR_W = 4;
   localparam int DEPTH  = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              ena = 1'b1;
   logic              ld_start = 1'b0;
   logic [DATA_W-1:0] ld_data = '0;
   logic              ld_valid = 1'b0;
   logic              ld_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              cpu_run;
   logic              busy;
   logic              error;

   int n_checks = 0;
   int n_pass   = 0;
   int writes_seen = 0;
   logic [DATA_W-1:0] shadow    [DEPTH];
   logic [DATA_W-1:0] mem_model [DEPTH];
   logic [DATA_W-1:0] img [$];

   cpu_prog_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .ena(ena), .ld_start(ld_start), .ld_data(ld_data),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .cpu_run(cpu_run), .busy(busy), .error(error)
   );

   always #5 clk = ~clk;

   // Program memory as the CPU would see it: written on the edge where mem_we is high.
   always @(posedge clk) begin
      if (mem_we === 1'b1) begin
         shadow[mem_addr] <= mem_wdata;
         writes_seen      <= writes_seen + 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_load(input string tag);
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
      n_checks++;
      if ({busy, ld_ready, cpu_run, error, mem_we} !== 5'b11000)
         $display("FAIL %s start: busy/ready/run/err/we got %b want 11000", tag,
                  {busy, ld_ready, cpu_run, error, mem_we});
      else n_pass++;
   endtask

   task automatic add_csum(input bit corrupt);
`ifdef LOADER_CSUM_EN
      logic [DATA_W-1:0] x;
      x = '0;
      for (int i = 1; i < img.size(); i++) x ^= img[i];
      if (corrupt) x ^= DATA_W'($urandom_range(1, 255));
      img.push_back(x);
`else
      if (corrupt) img.push_back('0);
      if (corrupt) void'(img.pop_back());
`endif
   endtask

   // Streams img (header, payload, optional checksum) and checks every step against
   // the outcome predicted from the image alone.
   task automatic run_img(input string tag, input bit gaps);
      int n;
      bit bad;
      bit exp_run;
      logic [DATA_W-1:0] x;
      int w0;
      n = int'(img[0]);
      bad = (n == 0) || (n > DEPTH);
      x = '0;
      if (!bad) for (int i = 1; i <= n; i++) x ^= img[i];
      exp_run = !bad;
`ifdef LOADER_CSUM_EN
      if (!bad) exp_run = (img[n + 1] == x);
`endif
      w0 = writes_seen;
      start_load(tag);
      for (int k = 0; k < img.size(); k++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               ld_valid = 1'b0;
               tick();
               n_checks++;
               if ({mem_we, busy} !== 2'b01)
                  $display("FAIL %s gap%0d: we/busy got %b want 01", tag, k, {mem_we, busy});
               else n_pass++;
            end
         end
         ld_valid = 1'b1;
         ld_data  = img[k];
         n_checks++;
         if (ld_ready !== 1'b1)
            $display("FAIL %s ready%0d: got %b want 1", tag, k, ld_ready);
         else n_pass++;
         tick();
         ld_valid = 1'b0;
         n_checks++;
         if (!bad && k >= 1 && k <= n) begin
            if ({mem_we, mem_addr, mem_wdata} !== {1'b1, ADDR_W'(k - 1), img[k]})
               $display("FAIL %s write%0d: we/addr/data got %b/%0d/%h want 1/%0d/%h", tag, k,
                        mem_we, mem_addr, mem_wdata, k - 1, img[k]);
            else n_pass++;
            mem_model[k-1] = img[k];
         end else begin
            if (mem_we !== 1'b0) $display("FAIL %s nowrite%0d: mem_we got %b want 0", tag, k, mem_we);
            else n_pass++;
         end
      end
      n_checks++;
      if ({cpu_run, error, busy, ld_ready} !== {exp_run, !exp_run, 2'b00})
         $display("FAIL %s end: run/err/busy/ready got %b want %b", tag,
                  {cpu_run, error, busy, ld_ready}, {exp_run, !exp_run, 2'b00});
      else n_pass++;
      tick();
      n_checks++;
      if (writes_seen - w0 != (bad ? 0 : n))
         $display("FAIL %s wcount: got %0d want %0d", tag, writes_seen - w0, bad ? 0 : n);
      else n_pass++;
      for (int a = 0; a < DEPTH; a++) begin
         n_checks++;
         if (shadow[a] !== mem_model[a])
            $display("FAIL %s mem[%0d]: got %h want %h", tag, a, shadow[a], mem_model[a]);
         else n_pass++;
      end
   endtask

   task automatic test_reset();
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({ld_ready, mem_we, mem_addr, mem_wdata, cpu_run, busy, error} !== '0)
         $display("FAIL reset_async: outputs got %b want 0",
                  {ld_ready, mem_we, mem_addr, mem_wdata, cpu_run, busy, error});
      else n_pass++;
      tick();
      rst = 1'b0;
      repeat (5) tick();
      n_checks++;
      if ({ld_ready, mem_we, mem_addr, mem_wdata, cpu_run, busy, error} !== '0)
         $display("FAIL reset_idle: outputs got %b want 0",
                  {ld_ready, mem_we, mem_addr, mem_wdata, cpu_run, busy, error});
      else n_pass++;
   endtask

   task automatic test_basic();
      img = '{8'd3, 8'hA1, 8'hB2, 8'hC3};
      add_csum(1'b0);
      run_img("basic", 1'b0);
   endtask

   task automatic test_bad_header();
      int w0;
      img = '{8'd0};
      run_img("hdr0", 1'b0);
      img = '{8'd17};
      run_img("hdr17", 1'b0);
      img = '{DATA_W'($urandom_range(18, 255))};
      run_img("hdr_big", 1'b1);
      // Error is sticky and the loader stays deaf until the next ld_start.
      w0 = writes_seen;
      ld_valid = 1'b1;
      ld_data  = 8'd2;
      repeat (3) tick();
      ld_valid = 1'b0;
      n_checks++;
      if ({error, cpu_run, ld_ready, writes_seen - w0} !== {3'b100, 32'd0})
         $display("FAIL err_sticky: err/run/ready got %b writes %0d want 100 writes 0",
                  {error, cpu_run, ld_ready}, writes_seen - w0);
      else n_pass++;
   endtask

`ifdef LOADER_CSUM_EN
   task automatic test_checksum();
      img = '{8'd2, 8'h11, 8'h22, 8'h00};
      run_img("csum_bad", 1'b0);
      img = '{8'd2, 8'h11, 8'h22, 8'h33};
      run_img("csum_good", 1'b0);
   endtask
`endif

   task automatic test_restart();
      logic [DATA_W-1:0] p [4];
      logic [DATA_W-1:0] q [4];
      int w0;
      for (int i = 0; i < 4; i++) begin
         p[i] = DATA_W'($urandom);
         q[i] = DATA_W'($urandom);
      end
      w0 = writes_seen;
      start_load("restart");
      ld_valid = 1'b1;
      ld_data  = 8'd4;
      tick();
      for (int i = 0; i < 2; i++) begin
         ld_data = p[i];
         tick();
         mem_model[i] = p[i];
      end
      ld_start = 1'b1;
      ld_data  = p[2];
      tick();
      ld_start = 1'b0;
      ld_valid = 1'b0;
      n_checks++;
      if ({mem_we, busy, ld_ready, cpu_run} !== 4'b0110)
         $display("FAIL restart_prio: we/busy/ready/run got %b want 0110",
                  {mem_we, busy, ld_ready, cpu_run});
      else n_pass++;
      tick();
      n_checks++;
      if (writes_seen - w0 != 2)
         $display("FAIL restart_partial: writes got %0d want 2", writes_seen - w0);
      else n_pass++;
      ld_valid = 1'b1;
      ld_data  = 8'd4;
      tick();
      for (int i = 0; i < 2; i++) begin
         ld_data = q[i];
         tick();
         n_checks++;
         if ({mem_we, mem_addr, mem_wdata} !== {1'b1, ADDR_W'(i), q[i]})
            $display("FAIL reload_w%0d: we/addr/data got %b/%0d/%h want 1/%0d/%h", i,
                     mem_we, mem_addr, mem_wdata, i, q[i]);
         else n_pass++;
         mem_model[i] = q[i];
      end
      ena     = 1'b0;
      ld_data = q[2];
      for (int c = 0; c < 3; c++) begin
         ld_start = (c == 1);
         tick();
         n_checks++;
         if ({mem_we, ld_ready, busy} !== 3'b001)
            $display("FAIL ena_low%0d: we/ready/busy got %b want 001", c,
                     {mem_we, ld_ready, busy});
         else n_pass++;
      end
      ld_start = 1'b0;
      ena      = 1'b1;
      for (int i = 2; i < 4; i++) begin
         ld_data = q[i];
         tick();
         n_checks++;
         if ({mem_we, mem_addr, mem_wdata} !== {1'b1, ADDR_W'(i), q[i]})
            $display("FAIL resume_w%0d: we/addr/data got %b/%0d/%h want 1/%0d/%h", i,
                     mem_we, mem_addr, mem_wdata, i, q[i]);
         else n_pass++;
         mem_model[i] = q[i];
      end
`ifdef LOADER_CSUM_EN
      ld_data = q[0] ^ q[1] ^ q[2] ^ q[3];
      tick();
`endif
      ld_valid = 1'b0;
      n_checks++;
      if ({cpu_run, error, busy} !== 3'b100)
         $display("FAIL restart_run: run/err/busy got %b want 100", {cpu_run, error, busy});
      else n_pass++;
      tick();
      n_checks++;
      if (writes_seen - w0 != 6)
         $display("FAIL restart_total: writes got %0d want 6", writes_seen - w0);
      else n_pass++;
   endtask

   task automatic test_full();
      img = '{8'd16};
      for (int i = 0; i < DEPTH; i++) img.push_back(DATA_W'($urandom));
      add_csum(1'b0);
      run_img("full", 1'b0);
   endtask

   task automatic test_async_reset();
      start_load("arst");
      ld_valid = 1'b1;
      ld_data  = 8'd2;
      tick();
      ld_data  = 8'h5A;
      tick();
      ld_valid = 1'b0;
      n_checks++;
      if (mem_we !== 1'b1) $display("FAIL arst_pre: mem_we got %b want 1", mem_we);
      else n_pass++;
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({ld_ready, mem_we, mem_addr, mem_wdata, cpu_run, busy, error} !== '0)
         $display("FAIL arst_mid: outputs got %b want 0",
                  {ld_ready, mem_we, mem_addr, mem_wdata, cpu_run, busy, error});
      else n_pass++;
      rst = 1'b0;
      tick();
      for (int a = 0; a < DEPTH; a++) begin
         n_checks++;
         if (shadow[a] !== mem_model[a])
            $display("FAIL arst mem[%0d]: got %h want %h", a, shadow[a], mem_model[a]);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      int n;
      for (int it = 0; it < 12; it++) begin
         if ($urandom_range(0, 7) == 0) begin
            img = '{DATA_W'($urandom_range(17, 255))};
         end else begin
            n = $urandom_range(1, DEPTH);
            img = '{DATA_W'(n)};
            for (int i = 0; i < n; i++) img.push_back(DATA_W'($urandom));
            add_csum($urandom_range(0, 2) == 0);
         end
         run_img($sformatf("rand%0d", it), $urandom_range(0, 1) == 1);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_bad_header();
`ifdef LOADER_CSUM_EN
      test_checksum();
`endif
      test_restart();
      test_full();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
